// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the register file slice.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_A,
    WR_HAVE_W,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_regbank.sv
// Register storage: byte-strobed write port, combinational read mux, per-register write pulse.
module axi4_lite_regbank
  import axi4_lite_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_REGS)-1:0]  wr_idx,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [STRB_W-1:0]            wr_strb,
  input  logic [$clog2(NUM_REGS)-1:0]  rd_idx,
  output logic [DATA_W-1:0]            rd_data,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage update and write pulse; a zero-strobe commit still pulses.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs     <= '{default: '0};
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (wr_en) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
        wr_pulse[wr_idx] <= 1'b1;
      end
    end
  end

  // Read mux and flattened export of all registers.
  always_comb begin
    rd_data  = regs[rd_idx];
    regs_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_out[DATA_W*i +: DATA_W] = regs[i];
    end
  end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register file: write and read FSMs, address capture and decode.
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [ADDR_WIDTH-1:0]       AWADDR,
  input  logic [2:0]                  AWPROT,
  input  logic                        WVALID,
  output logic                        WREADY,
  input  logic [31:0]                 WDATA,
  input  logic [3:0]                  WSTRB,
  output logic                        BVALID,
  input  logic                        BREADY,
  output logic [1:0]                  BRESP,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  input  logic [ADDR_WIDTH-1:0]       ARADDR,
  input  logic [2:0]                  ARPROT,
  output logic                        RVALID,
  input  logic                        RREADY,
  output logic [31:0]                 RDATA,
  output logic [1:0]                  RRESP,
  output logic [NUM_REGS*32-1:0]      regs_out,
  output logic [NUM_REGS-1:0]         wr_pulse
);

  localparam int unsigned IDXW = $clog2(NUM_REGS);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;

  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [31:0]           rd_data;
  logic                  unused_bits;

  // Commit uses the captured half of the pair plus the live half arriving this cycle.
  assign wr_addr     = (wr_state == WR_HAVE_A) ? aw_addr_q : AWADDR;
  assign wr_data     = (wr_state == WR_HAVE_W) ? w_data_q  : WDATA;
  assign wr_strb     = (wr_state == WR_HAVE_W) ? w_strb_q  : WSTRB;
  assign wr_in_range = (wr_addr >> (IDXW + 2)) == '0;
  assign rd_in_range = (ARADDR  >> (IDXW + 2)) == '0;
  assign unused_bits = ^{AWPROT, ARPROT, wr_addr[1:0], ARADDR[1:0]};

  // Write and read state registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Write FSM: AW and W may arrive in either order or together; READYs held low in reset.
  always_comb begin
    wr_next = wr_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    commit  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        AWREADY = 1'b1;
        WREADY  = 1'b1;
        if (AWVALID && WVALID) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end else if (AWVALID) begin
          wr_next = WR_HAVE_A;
        end else if (WVALID) begin
          wr_next = WR_HAVE_W;
        end
      end
      WR_HAVE_A: begin
        WREADY = 1'b1;
        if (WVALID) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end
      end
      WR_HAVE_W: begin
        AWREADY = 1'b1;
        if (AWVALID) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        BVALID = 1'b1;
        if (BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
    if (ARESET) begin
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      commit  = 1'b0;
    end
  end

  // Read FSM: one response outstanding at a time.
  always_comb begin
    rd_next = rd_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        ARREADY = !ARESET;
        if (ARVALID) rd_next = RD_RESP;
      end
      RD_RESP: begin
        RVALID = 1'b1;
        if (RREADY) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // Capture of early AW / W halves and the write response code.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      BRESP     <= RESP_OKAY;
    end else begin
      if (AWVALID && AWREADY) aw_addr_q <= AWADDR;
      if (WVALID && WREADY) begin
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (commit) BRESP <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read data register; the mux sees pre-write contents on a same-edge commit.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      RDATA <= '0;
      RRESP <= RESP_OKAY;
    end else if (ARVALID && ARREADY) begin
      RDATA <= rd_in_range ? rd_data : '0;
      RRESP <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  axi4_lite_regbank #(
    .NUM_REGS(NUM_REGS)
  ) u_regbank (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .wr_en    (commit && wr_in_range),
    .wr_idx   (wr_addr[IDXW+1:2]),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .rd_idx   (ARADDR[IDXW+1:2]),
    .rd_data  (rd_data),
    .regs_out (regs_out),
    .wr_pulse (wr_pulse)
  );

endmodule
